// File: rtl/udseq_pkg.sv
// Shared types and constants for the up/down sequence controller.
// Optional feature macro: UDSEQ_PASS_IDX_EN (see updown_seq_ctrl).
package udseq_pkg;

    // Controller states; RUN_UP/RUN_DN are the only states presenting valid data.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN_UP = 2'b01,
        RUN_DN = 2'b10,
        FIN    = 2'b11
    } state_t;

    // Direction mode encodings as seen on the mode input.
    localparam logic [1:0] MODE_UP  = 2'b00;
    localparam logic [1:0] MODE_DN  = 2'b01;
    localparam logic [1:0] MODE_PP  = 2'b10;
    localparam logic [1:0] MODE_RSV = 2'b11;

    // A start request is only honoured for a defined mode.
    function automatic logic mode_ok(input logic [1:0] m);
        return m != MODE_RSV;
    endfunction

endpackage

// File: rtl/updown_seq_ctrl_step.sv
// updown_step: N-bit loadable up/down count register.
// load has priority over en; dir=1 counts up, dir=0 counts down.
// Range checks live in the controller, so this register never needs to wrap.
module updown_step #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         dir,
    output logic [N-1:0] q
);

    // Count register: load a pass start value or step by one.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= dir ? q + 1'b1 : q - 1'b1;
        end
    end

endmodule

// File: rtl/updown_seq_ctrl.sv
// updown_seq_ctrl: steps a count register through [lo, hi] in up, down or
// ping-pong order for repeats+1 passes, presenting each value on a
// valid/ready handshake.
// Optional feature: define UDSEQ_PASS_IDX_EN to add the pass_idx output.
module updown_seq_ctrl
    import udseq_pkg::*;
#(
    parameter int N     = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [N-1:0]     lo,
    input  logic [N-1:0]     hi,
    input  logic [REP_W-1:0] repeats,
    input  logic             abort,
    output logic [N-1:0]     value,
    output logic             valid,
    input  logic             ready,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef UDSEQ_PASS_IDX_EN
    ,
    output logic [REP_W-1:0] pass_idx
`endif
);

    state_t           state, state_n;
    logic [1:0]       mode_q;
    logic [N-1:0]     lo_q, hi_q;
    logic [REP_W-1:0] rep_cnt;
    logic             err_q, err_n;

    logic             cfg_load;
    logic             pass_adv;
    logic             pass_end;
    logic             step_load, step_en, step_dir;
    logic [N-1:0]     step_load_val;
    logic [N-1:0]     cur_val;

    updown_step #(.N(N)) u_step (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (step_load),
        .load_val (step_load_val),
        .en       (step_en),
        .dir      (step_dir),
        .q        (cur_val)
    );

    // The presented value is the end of the current pass: hi on an up run
    // (or a single-value ping-pong), lo on any down run.
    assign pass_end = ((state == RUN_UP) && (cur_val == hi_q) &&
                       ((mode_q == MODE_UP) || (lo_q == hi_q))) ||
                      ((state == RUN_DN) && (cur_val == lo_q));

    assign valid = (state == RUN_UP) || (state == RUN_DN);
    assign busy  = (state != IDLE);
    assign done  = (state == FIN);
    assign last  = valid && pass_end && (rep_cnt == '0);
    assign value = cur_val;
    assign err   = err_q;

    // Next-state and count-register control; value only moves on a handshake.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_n       = state;
        step_load     = 1'b0;
        step_load_val = lo_q;
        step_en       = 1'b0;
        step_dir      = 1'b1;
        cfg_load      = 1'b0;
        pass_adv      = 1'b0;
        err_n         = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if ((lo > hi) || !mode_ok(mode)) begin
                        err_n = 1'b1;
                    end else begin
                        cfg_load  = 1'b1;
                        step_load = 1'b1;
                        if (mode == MODE_DN) begin
                            step_load_val = hi;
                            state_n       = RUN_DN;
                        end else begin
                            step_load_val = lo;
                            state_n       = RUN_UP;
                        end
                    end
                end
            end
            RUN_UP, RUN_DN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (ready) begin
                    if (pass_end) begin
                        if (rep_cnt == '0) begin
                            state_n = FIN;
                        end else begin
                            // Next pass restarts at its own start value.
                            pass_adv  = 1'b1;
                            step_load = 1'b1;
                            if (mode_q == MODE_DN) begin
                                step_load_val = hi_q;
                                state_n       = RUN_DN;
                            end else begin
                                step_load_val = lo_q;
                                state_n       = RUN_UP;
                            end
                        end
                    end else if (state == RUN_UP) begin
                        step_en = 1'b1;
                        if ((mode_q == MODE_PP) && (cur_val == hi_q)) begin
                            // Turn around: hi is not repeated on the way down.
                            step_dir = 1'b0;
                            state_n  = RUN_DN;
                        end
                    end else begin
                        step_en  = 1'b1;
                        step_dir = 1'b0;
                    end
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register plus the registered error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            err_q <= err_n;
        end
    end

    // Configuration latched at an accepted start; held for the whole sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_UP;
            lo_q   <= '0;
            hi_q   <= '0;
        end else if (cfg_load) begin
            mode_q <= mode;
            lo_q   <= lo;
            hi_q   <= hi;
        end
    end

    // Remaining-pass counter, independent of the value register; saturates at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
        end else if (cfg_load) begin
            rep_cnt <= repeats;
        end else if (pass_adv && (rep_cnt != '0)) begin
            rep_cnt <= rep_cnt - 1'b1;
        end
    end

`ifdef UDSEQ_PASS_IDX_EN
    // 0-based index of the pass currently being emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_idx <= '0;
        end else if (cfg_load) begin
            pass_idx <= '0;
        end else if (pass_adv) begin
            pass_idx <= pass_idx + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Self-checking bench for updown_seq_ctrl (N=4, REP_W=4).
// Expected streams are built from the range/mode/repeat rules with plain
// loops into queues; outputs are sampled on the falling clock edge.
// Honours UDSEQ_PASS_IDX_EN when defined.
module tb_updown_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, ready;
    logic [1:0] mode;
    logic [3:0] lo, hi, repeats;
    logic [3:0] value;
    logic       valid, last, busy, done, err;
`ifdef UDSEQ_PASS_IDX_EN
    logic [3:0] pass_idx;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    updown_seq_ctrl #(.N(4), .REP_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mode    (mode),
        .lo      (lo),
        .hi      (hi),
        .repeats (repeats),
        .abort   (abort),
        .value   (value),
        .valid   (valid),
        .ready   (ready),
        .last    (last),
        .busy    (busy),
        .done    (done),
        .err     (err)
`ifdef UDSEQ_PASS_IDX_EN
        ,
        .pass_idx(pass_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // stop_kind: 0 = abort at stop_idx, 1 = reset at stop_idx; stop_idx<0 runs to completion.
    // ready_mode: 0 = always ready, 1 = ready every other cycle, 2 = random ready and noise.
    task automatic run_seq(input logic [1:0] m, input int l, input int h, input int r,
                           input int ready_mode, input int stop_idx, input int stop_kind);
        logic [3:0] exp_v[$];
        logic [3:0] exp_p[$];
        int idx = 0;
        int cyc = 0;
        for (int p = 0; p <= r; p++) begin
            if (m == 2'b01) begin
                for (int v = h; v >= l; v--) begin exp_v.push_back(4'(v)); exp_p.push_back(4'(p)); end
            end else begin
                for (int v = l; v <= h; v++) begin exp_v.push_back(4'(v)); exp_p.push_back(4'(p)); end
                if (m == 2'b10)
                    for (int v = h - 1; v >= l; v--) begin exp_v.push_back(4'(v)); exp_p.push_back(4'(p)); end
            end
        end

        start = 1'b1; mode = m; lo = 4'(l); hi = 4'(h); repeats = 4'(r); ready = 1'b0;
        tick();
        start = 1'b0;
        check("first_valid", {31'd0, valid}, 1);
        check("first_busy", {31'd0, busy}, 1);

        while (idx < exp_v.size() && cyc < 2000) begin
            check("value", {28'd0, value}, {28'd0, exp_v[idx]});
            check("valid", {31'd0, valid}, 1);
            check("last", {31'd0, last}, (idx == exp_v.size() - 1) ? 1 : 0);
`ifdef UDSEQ_PASS_IDX_EN
            check("pass_idx", {28'd0, pass_idx}, {28'd0, exp_p[idx]});
`endif
            if (idx == stop_idx) begin
                start = 1'b0;
                if (stop_kind == 0) begin
                    abort = 1'b1; ready = 1'b1;
                    tick();
                    abort = 1'b0; ready = 1'b0;
                    check("abort_valid", {31'd0, valid}, 0);
                    check("abort_last", {31'd0, last}, 0);
                    check("abort_busy", {31'd0, busy}, 0);
                    check("abort_done", {31'd0, done}, 0);
                    tick();
                    check("abort_no_done", {31'd0, done}, 0);
                end else begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_value", {28'd0, value}, 0);
                    check("rst_valid", {31'd0, valid}, 0);
                    check("rst_last", {31'd0, last}, 0);
                    check("rst_busy", {31'd0, busy}, 0);
                    check("rst_done", {31'd0, done}, 0);
                    check("rst_err", {31'd0, err}, 0);
`ifdef UDSEQ_PASS_IDX_EN
                    check("rst_pass_idx", {28'd0, pass_idx}, 0);
`endif
                    @(negedge clk);
                    rst_n = 1'b1; ready = 1'b0;
                    tick();
                end
                return;
            end
            case (ready_mode)
                0: ready = 1'b1;
                1: ready = cyc[0];
                default: begin
                    ready   = 1'($urandom_range(0, 1));
                    start   = 1'($urandom_range(0, 1));
                    mode    = 2'($urandom);
                    lo      = 4'($urandom);
                    hi      = 4'($urandom);
                    repeats = 4'($urandom);
                end
            endcase
            tick();
            if (ready) idx++;
            cyc++;
        end
        start = 1'b0; ready = 1'b0;
        check("all_values_seen", idx, exp_v.size());
        check("fin_valid", {31'd0, valid}, 0);
        check("fin_done", {31'd0, done}, 1);
        check("fin_busy", {31'd0, busy}, 1);
        tick();
        check("idle_done", {31'd0, done}, 0);
        check("idle_busy", {31'd0, busy}, 0);
        check("idle_valid", {31'd0, valid}, 0);
    endtask

    task automatic bad_start(input logic [1:0] m, input int l, input int h, input logic with_abort);
        start = 1'b1; abort = with_abort; mode = m; lo = 4'(l); hi = 4'(h); repeats = 4'd1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("bad_err", {31'd0, err}, with_abort ? 0 : 1);
        check("bad_valid", {31'd0, valid}, 0);
        check("bad_busy", {31'd0, busy}, 0);
        tick();
        check("bad_err_pulse", {31'd0, err}, 0);
        check("bad_valid2", {31'd0, valid}, 0);
        check("bad_busy2", {31'd0, busy}, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b0;
        mode = 2'b00; lo = 4'd0; hi = 4'd0; repeats = 4'd0;
        #1;
        check("reset_value", {28'd0, value}, 0);
        check("reset_valid", {31'd0, valid}, 0);
        check("reset_last", {31'd0, last}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_err", {31'd0, err}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed cases.
        run_seq(2'b00, 3, 6, 1, 0, -1, 0);
        run_seq(2'b10, 0, 2, 0, 1, -1, 0);
        run_seq(2'b01, 0, 15, 0, 0, -1, 0);
        run_seq(2'b00, 0, 15, 0, 0, -1, 0);
        run_seq(2'b10, 5, 5, 2, 1, -1, 0);
        run_seq(2'b01, 7, 7, 1, 0, -1, 0);
        bad_start(2'b00, 9, 4, 1'b0);
        bad_start(2'b11, 2, 8, 1'b0);
        bad_start(2'b00, 2, 8, 1'b1);
        run_seq(2'b00, 0, 7, 0, 0, 2, 0);
        run_seq(2'b00, 0, 7, 0, 0, -1, 0);
        run_seq(2'b10, 1, 6, 1, 0, 7, 1);
        run_seq(2'b10, 1, 6, 2, 1, -1, 0);

        // Randomized legal and illegal configurations.
        for (int t = 0; t < 24; t++) begin
            int a = $urandom_range(0, 15);
            int b = $urandom_range(0, 15);
            if (t % 6 == 5) begin
                if (a == b) bad_start(2'b11, a, b, 1'b0);
                else bad_start(2'($urandom_range(0, 2)), (a > b) ? a : b, (a > b) ? b : a, 1'b0);
            end else begin
                run_seq(2'($urandom_range(0, 2)), (a < b) ? a : b, (a < b) ? b : a,
                        $urandom_range(0, 2), 2, -1, 0);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
